testport_write_capture: RTL and testbench

// - Sits between the CPU/D-cache memory-write bus and the result checker; snoops stores to the test port word address.
// - Frames one test run between BEGIN_SYM and END_SYM and de-duplicates stores held high across D-cache stalls.
// - Converts each store from little-endian to readable byte order and buffers it in a FIFO; the checker drains it via valid/ready.

---
 rtl/testport_write_capture.sv | 180 ++++++++++++++++++
 tb/tb_testport_write_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testport_write_capture.sv
// Snoops CPU stores to the test port, frames a run between BEGIN_SYM and END_SYM, and queues byte-swapped words for the checker.
// Optional feature: define TESTPORT_TIMESTAMP_EN to add a per-entry out_stamp (cycles since the run was armed).
module testport_write_capture #(
  parameter logic [29:0] TEST_PORT = 30'h3FF,
  parameter logic [31:0] BEGIN_SYM = 32'h00000168,
  parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
`ifdef TESTPORT_TIMESTAMP_EN
  output logic [15:0] out_stamp,
`endif
  output logic        active,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t        state_r, state_s;
  logic          held_r;
  logic [31:0]   swap_s;
  logic          hit_s, push_s, arm_s, last_s;
  logic          full_s, empty_s, pop_s, wr_en_s, drop_s;
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic [15:0]   word_cnt_r;
  logic          overflow_r;
  logic [31:0]   data_mem_r [DEPTH];
  logic          last_mem_r [DEPTH];

  assign swap_s  = byte_swap(mem_wdata);
  // A store held across a stall counts once; held_r masks the repeat cycles.
  assign hit_s   = mem_wen && (mem_addr == TEST_PORT) && !held_r;
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = !empty_s && out_ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Store-held tracker for de-duplication
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r <= 1'b0;
    end else begin
      held_r <= mem_wen;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and push decision
  always_comb begin
    state_s = state_r;
    push_s  = 1'b0;
    arm_s   = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s && (swap_s == BEGIN_SYM)) begin
          state_s = ARMED;
          arm_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (hit_s) begin
          push_s = 1'b1;
          if (swap_s == END_SYM) begin
            last_s  = 1'b1;
            state_s = DONE;
          end else begin
            state_s = ARMED;
          end
        end else begin
          state_s = ARMED;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Run statistics: cleared when a run is armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_r <= 16'h0000;
      overflow_r <= 1'b0;
    end else if (arm_s) begin
      word_cnt_r <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      if (push_s && (word_cnt_r != 16'hFFFF)) begin
        word_cnt_r <= word_cnt_r + 16'h0001;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // FIFO storage; a full-FIFO write lands in the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_mem_r[wr_ptr_r[AW-1:0]] <= swap_s;
      last_mem_r[wr_ptr_r[AW-1:0]] <= last_s;
    end
  end

`ifdef TESTPORT_TIMESTAMP_EN
  logic [15:0] stamp_cnt_r;
  logic [15:0] stamp_mem_r [DEPTH];

  // Cycles since arming, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_cnt_r <= 16'h0000;
    end else if (arm_s) begin
      stamp_cnt_r <= 16'h0000;
    end else if ((state_r != IDLE) && (stamp_cnt_r != 16'hFFFF)) begin
      stamp_cnt_r <= stamp_cnt_r + 16'h0001;
    end
  end

  // Per-entry timestamp storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      stamp_mem_r[wr_ptr_r[AW-1:0]] <= stamp_cnt_r;
    end
  end

  assign out_stamp = empty_s ? 16'h0000 : stamp_mem_r[rd_ptr_r[AW-1:0]];
`endif

  assign out_valid = !empty_s;
  assign out_data  = empty_s ? 32'h00000000 : data_mem_r[rd_ptr_r[AW-1:0]];
  assign out_last  = empty_s ? 1'b0 : last_mem_r[rd_ptr_r[AW-1:0]];
  assign active    = (state_r == ARMED);
  assign done      = (state_r == DONE);
  assign overflow  = overflow_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_testport_write_capture.sv
// Self-checking bench for testport_write_capture: directed scenarios plus randomized runs against an event-level model.
module tb_testport_write_capture;

  localparam logic [31:0] BEGIN_R = 32'h00000168;
  localparam logic [31:0] END_R   = 32'hFFFFFD5D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] mem_addr = 30'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_wen = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, active, done, overflow;
  logic [31:0] out_data;
  logic [15:0] word_cnt;
`ifdef TESTPORT_TIMESTAMP_EN
  logic [15:0] out_stamp;
`endif

  int checks = 0;
  int errors = 0;

  // Event-level model: one entry per store event, FIFO as a queue of {last,data}
  int          m_mode;   // 0 idle, 1 armed, 2 done
  int          m_cnt;
  bit          m_ovf;
  logic [32:0] m_q[$];

  testport_write_capture dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
`ifdef TESTPORT_TIMESTAMP_EN
    .out_stamp(out_stamp),
`endif
    .active(active), .done(done), .overflow(overflow), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] readable(input logic [31:0] w);
    logic [31:0] r;
    r = {<<8{w}};
    return r;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_cnt = 0; m_ovf = 1'b0; m_q.delete();
  endtask

  task automatic model_store(input logic [29:0] a, input logic [31:0] w);
    logic [31:0] r;
    r = readable(w);
    if (a == 30'h3FF) begin
      if (m_mode == 0 && r == BEGIN_R) begin
        m_mode = 1; m_cnt = 0; m_ovf = 1'b0;
      end else if (m_mode == 1) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_q.size() < 8) m_q.push_back({(r == END_R), r});
        else m_ovf = 1'b1;
        if (r == END_R) m_mode = 2;
      end
    end
  endtask

  // One store event: wen high for 'hold' cycles, then one wen-low cycle; returns at a negedge.
  task automatic store(input logic [29:0] a, input logic [31:0] w, input int hold);
    mem_addr = a; mem_wdata = w; mem_wen = 1'b1;
    model_store(a, w);
    repeat (hold) @(negedge clk);
    mem_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0; mem_wen = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, active, done, overflow, word_cnt, out_data, out_last} !== 53'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%b d=%b o=%b cnt=%h data=%h last=%b want all 0",
               out_valid, active, done, overflow, word_cnt, out_data, out_last);
    end
    rst = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_arm();
    store(30'h3FF, 32'h68010000, 1);
    checks++;
    if ({active, out_valid, word_cnt} !== {1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL arm got active=%b valid=%b cnt=%h want 1 0 0000", active, out_valid, word_cnt);
    end
  endtask

  task automatic test_dedup();
    store(30'h3FF, 32'h01000000, 5);
    checks++;
    if ({out_valid, out_data, word_cnt} !== {1'b1, 32'h1, 16'h1}) begin
      errors++;
      $display("FAIL dedup got valid=%b data=%h cnt=%h want 1 00000001 0001", out_valid, out_data, word_cnt);
    end
    out_ready = 1'b1;
    void'(m_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dedup_single_push got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_end_frame();
    logic [32:0] exp;
    int n;
    store(30'h3FF, readable(32'h0), 1);
    store(30'h3FF, readable(32'h1), 2);
    store(30'h3FF, readable(32'h2), 1);
    store(30'h3FF, 32'h5DFDFFFF, 3);
    checks++;
    if ({done, active} !== 2'b10) begin
      errors++;
      $display("FAIL end_state got done=%b active=%b want 1 0", done, active);
    end
    out_ready = 1'b1; n = 0;
    while (out_valid === 1'b1 && n < 20) begin
      checks++;
      if (m_q.size() == 0) begin
        errors++;
        $display("FAIL end_drain_extra got data=%h want empty", out_data);
      end else begin
        exp = m_q.pop_front();
        if ({out_last, out_data} !== exp) begin
          errors++;
          $display("FAIL end_drain got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[32], exp[31:0]);
        end
      end
      @(negedge clk); n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 4 || m_q.size() != 0) begin
      errors++;
      $display("FAIL end_drain_count got %0d words want 4 (model left %0d)", n, m_q.size());
    end
    store(30'h3FF, readable(32'h7), 1);
    checks++;
    if ({out_valid, done, word_cnt} !== {1'b0, 1'b1, 16'(m_cnt)}) begin
      errors++;
      $display("FAIL done_ignores got valid=%b done=%b cnt=%h want 0 1 %h", out_valid, done, word_cnt, 16'(m_cnt));
    end
  endtask

  task automatic test_ignored();
    do_reset();
    store(30'h3FF, readable(32'h12345678), 1);
    store(30'h3FE, 32'h68010000, 1);
    checks++;
    if ({active, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ignore got active=%b valid=%b want 0 0", active, out_valid);
    end
    store(30'h3FF, 32'h68010000, 1);
    store(30'h3FE, readable(32'h55), 1);
    checks++;
    if ({active, out_valid, word_cnt} !== {1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL wrong_addr got active=%b valid=%b cnt=%h want 1 0 0000", active, out_valid, word_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [32:0] exp;
    int n;
    do_reset();
    store(30'h3FF, 32'h68010000, 1);
    for (int i = 0; i < 10; i++) store(30'h3FF, readable(32'h100 + i), 1);
    checks++;
    if ({overflow, word_cnt, out_data} !== {1'b1, 16'd10, 32'h100}) begin
      errors++;
      $display("FAIL overflow got ovf=%b cnt=%0d head=%h want 1 10 00000100", overflow, word_cnt, out_data);
    end
    // Full FIFO: push and pop on the same edge
    mem_addr = 30'h3FF; mem_wdata = readable(32'hABCD); mem_wen = 1'b1; out_ready = 1'b1;
    void'(m_q.pop_front());
    model_store(30'h3FF, readable(32'hABCD));
    @(negedge clk);
    mem_wen = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({word_cnt, out_data} !== {16'd11, 32'h101}) begin
      errors++;
      $display("FAIL push_pop_full got cnt=%0d head=%h want 11 00000101", word_cnt, out_data);
    end
    out_ready = 1'b1; n = 0;
    while (out_valid === 1'b1 && n < 20) begin
      checks++;
      if (m_q.size() == 0) begin
        errors++;
        $display("FAIL ovf_drain_extra got data=%h want empty", out_data);
      end else begin
        exp = m_q.pop_front();
        if ({out_last, out_data} !== exp) begin
          errors++;
          $display("FAIL ovf_drain got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[32], exp[31:0]);
        end
      end
      @(negedge clk); n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 8 || m_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain_count got %0d words want 8 (model left %0d)", n, m_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    store(30'h3FF, 32'h68010000, 1);
    for (int i = 0; i < 3; i++) store(30'h3FF, readable(32'h20 + i), 1);
    #1 rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({out_valid, active, word_cnt} !== {1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset got valid=%b active=%b cnt=%h want 0 0 0000", out_valid, active, word_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [29:0] a;
    logic [31:0] w;
    int n, sel;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      store(30'h3FF, 32'h68010000, $urandom_range(1, 3));
      for (int s = 0; s < $urandom_range(1, 12); s++) begin
        sel = $urandom_range(0, 3);
        a = (sel < 2) ? 30'h3FF : (sel == 2) ? 30'h3FE : 30'($urandom);
        sel = $urandom_range(0, 7);
        w = (sel == 0) ? readable(END_R) : (sel == 1) ? readable(BEGIN_R) : $urandom;
        store(a, w, $urandom_range(1, 4));
        checks++;
        if ({active, done, overflow, word_cnt, out_valid} !==
            {(m_mode == 1), (m_mode == 2), m_ovf, 16'(m_cnt), (m_q.size() != 0)}) begin
          errors++;
          $display("FAIL rand_status got a=%b d=%b o=%b cnt=%0d v=%b want a=%b d=%b o=%b cnt=%0d v=%b",
                   active, done, overflow, word_cnt, out_valid,
                   (m_mode == 1), (m_mode == 2), m_ovf, m_cnt, (m_q.size() != 0));
        end
      end
      out_ready = 1'b1; n = 0;
      while (out_valid === 1'b1 && n < 20) begin
        checks++;
        if (m_q.size() == 0) begin
          errors++;
          $display("FAIL rand_drain_extra got data=%h want empty", out_data);
        end else begin
          exp = m_q.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL rand_drain got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[32], exp[31:0]);
          end
        end
        @(negedge clk); n++;
      end
      out_ready = 1'b0;
      checks++;
      if (m_q.size() != 0) begin
        errors++;
        $display("FAIL rand_drain_missing got valid=%b want %0d more words", out_valid, m_q.size());
      end
    end
  endtask

  initial begin
    model_clear();
    #3;
    test_reset();
    test_arm();
    test_dedup();
    test_end_frame();
    test_ignored();
    test_overflow();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
